change_dispenser: RTL and testbench

Sequencer that turns a change amount (cents) into a sequence of physical coin ejections, one coin at a time, over a req/ack handshake to the coin ejector mechanism. It sits between the vending machine controller (which supplies the amount and the current coin stock) and the ejector. It first plans the coin mix against the available stock, then dispenses. It reports success or failure so the controller can sell the product or refund.

---
 rtl/vm_pkg.sv | 36 +++
 rtl/change_dispenser_if.sv | 10 +
 rtl/coin_eject_hs.sv | 69 ++++++
 rtl/change_dispenser.sv | 152 +++++++++++++++
 tb/tb_change_dispenser.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes and values, packed coin
// vector layout, the dispenser state enum and the greedy planning helper.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_25   = 2'd1;
  localparam logic [1:0] COIN_50   = 2'd2;
  localparam logic [1:0] COIN_100  = 2'd3;

  localparam logic [7:0] VAL_25  = 8'd25;
  localparam logic [7:0] VAL_50  = 8'd50;
  localparam logic [7:0] VAL_100 = 8'd100;

  // Bit offsets of each 8-bit count inside a packed 24-bit coin vector.
  localparam int F25_LSB  = 0;
  localparam int F50_LSB  = 8;
  localparam int F100_LSB = 16;

  typedef enum logic [3:0] {
    IDLE, P100, P50, P25, CHK, REQ, WAIT_ACK, WAIT_REL, FIN
  } disp_state_t;

  // min(avail, rem / val) without a divider: rem <= 255 and val >= 25, so
  // the quotient is at most 10 and a handful of comparisons covers it.
  function automatic logic [7:0] plan_count(input logic [7:0] rem,
                                            input logic [7:0] val,
                                            input logic [7:0] avail);
    logic [7:0] q;
    q = '0;
    for (int k = 1; k <= 10; k++) begin
      if ({8'd0, rem} >= 16'(k) * {8'd0, val}) q = 8'(k);
    end
    return (q < avail) ? q : avail;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin ejector handshake: the dispenser requests one coin at a time and the
// ejector answers with a level acknowledge.
interface change_dispenser_if;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       coin_ack;

  modport master (output coin_req, output coin_sel, input coin_ack);
  modport slave  (input coin_req, input coin_sel, output coin_ack);
endinterface

// File: rtl/coin_eject_hs.sv
// Single-coin req/ack handshake with a bounded ack wait and a release wait.
// ok is a combinational strobe on the edge the ack is accepted; timeout is a
// combinational strobe on the edge the wait budget runs out.
module coin_eject_hs
  import vm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic [1:0] sel,
  output logic       ok,
  output logic       timeout,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  input  logic       coin_ack
);

  localparam int             CW   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {HS_IDLE, HS_ACK, HS_REL} hs_state_t;

  hs_state_t     hs;
  logic [CW-1:0] cnt;

  assign ok      = (hs == HS_ACK) && coin_ack;
  assign timeout = (hs == HS_ACK) && !coin_ack && (cnt == LAST);

  // Handshake sequencer: raise req, wait for ack (bounded), then wait release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs       <= HS_IDLE;
      cnt      <= '0;
      coin_req <= 1'b0;
      coin_sel <= COIN_NONE;
    end else begin
      case (hs)
        HS_IDLE: begin
          if (go) begin
            hs       <= HS_ACK;
            cnt      <= '0;
            coin_req <= 1'b1;
            coin_sel <= sel;
          end
        end
        HS_ACK: begin
          if (coin_ack) begin
            hs       <= HS_REL;
            coin_req <= 1'b0;
            coin_sel <= COIN_NONE;
          end else if (cnt == LAST) begin
            hs       <= HS_IDLE;
            coin_req <= 1'b0;
            coin_sel <= COIN_NONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HS_REL: begin
          if (!coin_ack) hs <= HS_IDLE;
        end
        default: hs <= HS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: plans a greedy 100/50/25 coin mix against the latched
// stock, then ejects the planned coins largest first through coin_eject_hs.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [7:0]          amount,
  input  logic [23:0]         stock,
  change_dispenser_if.master  ej,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [23:0]         coins_used
);

  disp_state_t state;
  logic [7:0]  rem;
  logic [23:0] stk;
  logic [7:0]  p100, p50, p25;
  logic        fin_fail;

  logic [7:0]  n100, n50, n25;
  logic [1:0]  next_sel;
  logic        hs_ok, hs_timeout;

  assign n100 = plan_count(rem, VAL_100, stk[F100_LSB +: 8]);
  assign n50  = plan_count(rem, VAL_50,  stk[F50_LSB  +: 8]);
  assign n25  = plan_count(rem, VAL_25,  stk[F25_LSB  +: 8]);

  assign busy = (state != IDLE);

  // Largest denomination still owed by the plan.
  always_comb begin
    next_sel = COIN_25;
    if (p100 != 8'd0)     next_sel = COIN_100;
    else if (p50 != 8'd0) next_sel = COIN_50;
  end

  coin_eject_hs #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_hs (
    .clock    (clock),
    .reset_n  (reset_n),
    .go       (state == REQ),
    .sel      (next_sel),
    .ok       (hs_ok),
    .timeout  (hs_timeout),
    .coin_req (ej.coin_req),
    .coin_sel (ej.coin_sel),
    .coin_ack (ej.coin_ack)
  );

  // Planner / dispense sequencer with registered done/fail/coins_used.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rem        <= '0;
      stk        <= '0;
      p100       <= '0;
      p50        <= '0;
      p25        <= '0;
      fin_fail   <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      coins_used <= '0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem        <= amount;
            stk        <= stock;
            p100       <= '0;
            p50        <= '0;
            p25        <= '0;
            coins_used <= '0;
            state      <= P100;
          end
        end
        P100: begin
          p100  <= n100;
          rem   <= rem - n100 * VAL_100;
          state <= P50;
        end
        P50: begin
          p50   <= n50;
          rem   <= rem - n50 * VAL_50;
          state <= P25;
        end
        P25: begin
          p25   <= n25;
          rem   <= rem - n25 * VAL_25;
          state <= CHK;
        end
        CHK: begin
          if (rem != 8'd0) begin
            fin_fail <= 1'b1;
            state    <= FIN;
          end else if ((p100 | p50 | p25) == 8'd0) begin
            fin_fail <= 1'b0;
            state    <= FIN;
          end else begin
            state <= REQ;
          end
        end
        REQ: state <= WAIT_ACK;
        WAIT_ACK: begin
          if (hs_ok) begin
            case (ej.coin_sel)
              COIN_100: begin
                p100 <= p100 - 8'd1;
                coins_used[F100_LSB +: 8] <= coins_used[F100_LSB +: 8] + 8'd1;
              end
              COIN_50: begin
                p50 <= p50 - 8'd1;
                coins_used[F50_LSB +: 8] <= coins_used[F50_LSB +: 8] + 8'd1;
              end
              default: begin
                p25 <= p25 - 8'd1;
                coins_used[F25_LSB +: 8] <= coins_used[F25_LSB +: 8] + 8'd1;
              end
            endcase
            state <= WAIT_REL;
          end else if (hs_timeout) begin
            fin_fail <= 1'b1;
            state    <= FIN;
          end
        end
        WAIT_REL: begin
          if (!ej.coin_ack) begin
            if ((p100 | p50 | p25) != 8'd0) begin
              state <= REQ;
            end else begin
              fin_fail <= 1'b0;
              state    <= FIN;
            end
          end
        end
        FIN: begin
          done  <= !fin_fail;
          fail  <= fin_fail;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random transactions,
// each checked against a greedy-plan reference model.
module tb_change_dispenser;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  amount = '0;
  logic [23:0] stock = '0;
  logic        busy, done, fail;
  logic [23:0] coins_used;

  int checks = 0;
  int errors = 0;

  change_dispenser_if ej ();

  change_dispenser #(.ACK_TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .amount     (amount),
    .stock      (stock),
    .ej         (ej.master),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .coins_used (coins_used)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transaction: acts as the ejector (ack 'delay' cycles after each req,
  // only for the first 'acks' coins) and compares against the greedy model.
  task automatic dispense(input logic [7:0] amt, input logic [23:0] stk,
                          input int delay, input int acks, input bit poke);
    int r, c100, c50, c25, u100, u50, u25;
    int s100, s50, s25, n_plan, n_req, cyc, req_start, req_hi, first_req, fin_cyc;
    bit feasible, exp_done, finished, got_done, got_fail, prev_req, poked;
    logic [1:0] plan_q[$];
    logic [1:0] got[$];

    s100 = int'(stk[23:16]);
    s50  = int'(stk[15:8]);
    s25  = int'(stk[7:0]);
    r = int'(amt);
    c100 = (r / 100 < s100) ? r / 100 : s100;  r = r - c100 * 100;
    c50  = (r / 50  < s50)  ? r / 50  : s50;   r = r - c50 * 50;
    c25  = (r / 25  < s25)  ? r / 25  : s25;   r = r - c25 * 25;
    feasible = (r == 0);
    for (int i = 0; i < c100; i++) plan_q.push_back(2'd3);
    for (int i = 0; i < c50; i++)  plan_q.push_back(2'd2);
    for (int i = 0; i < c25; i++)  plan_q.push_back(2'd1);
    n_plan = plan_q.size();
    exp_done = feasible && (acks >= n_plan);
    n_req = !feasible ? 0 : ((acks < n_plan) ? acks + 1 : n_plan);
    u100 = 0; u50 = 0; u25 = 0;
    if (feasible) begin
      for (int i = 0; i < n_plan && i < acks; i++) begin
        if (plan_q[i] == 2'd3) u100++;
        else if (plan_q[i] == 2'd2) u50++;
        else u25++;
      end
    end

    @(posedge clock); #1;
    start = 1'b1; amount = amt; stock = stk;
    @(posedge clock); #1;
    start = 1'b0; amount = 8'($urandom); stock = 24'($urandom);
    cyc = 0; finished = 0; prev_req = 0; poked = 0;
    req_start = 0; req_hi = 0; first_req = -1; fin_cyc = -1;
    got_done = 0; got_fail = 0;
    while (!finished && cyc < 400) begin
      @(posedge clock); #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) check("busy_planning", busy, 1'b1);
      if (!ej.coin_req) check("sel_idle_zero", ej.coin_sel, 2'd0);
      if (ej.coin_req && !prev_req) begin
        if (first_req < 0) first_req = cyc;
        got.push_back(ej.coin_sel);
        req_start = cyc;
        req_hi = 0;
        if (poke && !poked) begin
          start = 1'b1; amount = 8'd25; stock = 24'hFFFFFF; poked = 1;
        end
      end
      if (ej.coin_req) req_hi++;
      if (ej.coin_req && !ej.coin_ack && acks > 0 && cyc - req_start >= delay) begin
        ej.coin_ack = 1'b1;
        acks--;
      end else if (!ej.coin_req && ej.coin_ack) begin
        ej.coin_ack = 1'b0;
      end
      prev_req = ej.coin_req;
      if (done || fail) begin
        finished = 1; fin_cyc = cyc; got_done = done; got_fail = fail;
        check("coins_used", coins_used, {8'(u100), 8'(u50), 8'(u25)});
        check("busy_at_end", busy, 1'b0);
      end
    end
    ej.coin_ack = 1'b0;
    start = 1'b0;
    if (!finished) begin
      check("completion_within_budget", 32'd0, 32'd1);
    end else begin
      check("done_outcome", got_done, exp_done);
      check("fail_outcome", got_fail, !exp_done);
      if (!feasible || n_plan == 0) check("finish_cycle", fin_cyc, 5);
      else check("first_req_cycle", first_req, 5);
      check("req_count", got.size(), n_req);
      for (int i = 0; i < got.size() && i < n_req; i++) check("coin_order", got[i], plan_q[i]);
      if (feasible && !exp_done) check("ack_wait_cycles", req_hi, TO);
      @(posedge clock); #1;
      check("pulse_one_cycle", {done, fail}, 2'b00);
    end
  endtask

  initial begin
    logic [7:0]  amt;
    logic [23:0] stk;
    ej.coin_ack = 1'b0;
    #2;
    check("rst_coin_req", ej.coin_req, 1'b0);
    check("rst_coin_sel", ej.coin_sel, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done_fail", {done, fail}, 2'b00);
    check("rst_coins_used", coins_used, 24'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Directed scenarios
    dispense(8'd75,  {8'd5, 8'd5, 8'd5}, 2, 100, 0);
    dispense(8'd100, {8'd0, 8'd1, 8'd4}, 1, 100, 0);
    dispense(8'd75,  {8'd5, 8'd5, 8'd0}, 0, 100, 0);
    dispense(8'd30,  {8'd9, 8'd9, 8'd9}, 0, 100, 0);
    dispense(8'd0,   {8'd9, 8'd9, 8'd9}, 0, 100, 0);
    dispense(8'd150, {8'd9, 8'd9, 8'd9}, 1, 1, 0);
    dispense(8'd250, {8'd2, 8'd0, 8'd2}, 0, 100, 1);

    // Asynchronous reset in the middle of a request
    @(posedge clock); #1;
    start = 1'b1; amount = 8'd200; stock = {8'd3, 8'd3, 8'd3};
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !ej.coin_req; i++) begin
      @(posedge clock); #1;
    end
    check("req_before_reset", ej.coin_req, 1'b1);
    start = 1'b1; amount = 8'd25;
    @(posedge clock); #1;
    start = 1'b0;
    check("start_ignored_sel", ej.coin_sel, 2'd3);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_drops_req", ej.coin_req, 1'b0);
    check("reset_drops_busy", busy, 1'b0);
    check("reset_clears_sel", ej.coin_sel, 2'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check("no_pulse_after_reset", {done, fail, busy}, 3'b000);
    end
    dispense(8'd125, {8'd1, 8'd0, 8'd1}, 1, 100, 0);

    // Random transactions
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) amt = 8'($urandom_range(0, 255));
      else amt = 8'($urandom_range(0, 10) * 25);
      stk = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 4))};
      dispense(amt, stk, int'($urandom_range(0, 3)),
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : 100,
               bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
